// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash responder and the instruction-fetch flash reader:
// opcodes, responder FSM states and the JEDEC ID byte selector.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_JEDEC = 8'h9F;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS_ON_WIRE = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_FETCH,
    ST_DATA,
    ST_ID,
    ST_STAT,
    ST_IGNORE
  } state_e;

  // Index 0..2 selects ID bytes MSB-first; anything past the ID reads as zero.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = id[23:16];
      2'd1:    b = id[15:8];
      2'd2:    b = id[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Brings SCK, CS# and MOSI into the system clock domain and derives SCK edge pulses.
module spi_input_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic mosi_o
);

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic cs_meta_q, cs_sync_q;
  logic mosi_meta_q, mosi_sync_q;

  // Presets model an idle bus: SCK low, CS# deasserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sck_meta_q  <= sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      cs_meta_q   <= cs_n_i;
      cs_sync_q   <= cs_meta_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sck_rise_o = sck_sync_q & ~sck_prev_q;
  assign sck_fall_o = ~sck_sync_q & sck_prev_q;
  assign cs_n_o     = cs_sync_q;
  assign mosi_o     = mosi_sync_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating a serial NOR flash (READ, RDSR, JEDEC ID),
// serving READ data from a byte-wide memory port with a one-byte prefetch.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4017,
  parameter logic [7:0]  STATUS    = 8'h00
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 spi_clk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic [7:0]           last_cmd
);

  localparam int unsigned SHIFT_W = (ADDR_BITS > 8) ? ADDR_BITS - 1 : 7;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic sck_rise, sck_fall, cs_n_s, mosi_s;

  spi_input_sync u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .sck_i      (spi_clk),
    .cs_n_i     (spi_cs_n),
    .mosi_i     (spi_mosi),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_n_o     (cs_n_s),
    .mosi_o     (mosi_s)
  );

  state_e               state_q;
  logic [4:0]           bit_cnt_q;
  logic [SHIFT_W-1:0]   shift_in_q;
  logic [7:0]           shift_out_q;
  logic [7:0]           pref_q;
  logic                 pref_valid_q;
  logic [2:0]           out_cnt_q;
  logic                 byte_done_q;
  logic [1:0]           id_idx_q;
  logic                 rd_pend_q;
  logic [1:0]           settle_q;
  logic                 armed_q;
  logic                 miso_q;
  logic                 mem_rd_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic                 busy_q;
  logic [7:0]           last_cmd_q;

  logic [7:0]           cmd_byte_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [7:0]           next_byte_d;
  logic [7:0]           out_byte_d;

  assign cmd_byte_d = {shift_in_q[6:0], mosi_s};
  assign addr_d     = {shift_in_q[ADDR_BITS-2:0], mosi_s};

  always_comb begin
    next_byte_d = 8'h00;
    unique case (state_q)
      ST_DATA: next_byte_d = pref_valid_q ? pref_q : 8'h00;
      ST_ID:   next_byte_d = id_byte(JEDEC_ID, id_idx_q);
      ST_STAT: next_byte_d = STATUS;
      default: next_byte_d = 8'h00;
    endcase
  end

  // A new byte is swapped in on the fall after bit 0 of the previous one went out.
  assign out_byte_d = byte_done_q ? next_byte_d : shift_out_q;

  // Transfers only start once CS# has been seen high after reset (settle_q waits out the sync presets).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_in_q   <= '0;
      shift_out_q  <= '0;
      pref_q       <= '0;
      pref_valid_q <= 1'b0;
      out_cnt_q    <= '0;
      byte_done_q  <= 1'b0;
      id_idx_q     <= '0;
      rd_pend_q    <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
      miso_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      last_cmd_q   <= '0;
    end else begin
      mem_rd_q  <= 1'b0;
      rd_pend_q <= mem_rd_q;
      busy_q    <= armed_q & ~cs_n_s;
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd3 && cs_n_s) begin
        armed_q <= 1'b1;
      end

      if (cs_n_s) begin
        state_q      <= ST_IDLE;
        miso_q       <= 1'b0;
        bit_cnt_q    <= '0;
        out_cnt_q    <= '0;
        byte_done_q  <= 1'b0;
        pref_valid_q <= 1'b0;
        id_idx_q     <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (armed_q) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
            end
          end

          ST_CMD: begin
            if (sck_rise) begin
              shift_in_q <= {shift_in_q[SHIFT_W-2:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                last_cmd_q  <= cmd_byte_d;
                bit_cnt_q   <= '0;
                out_cnt_q   <= '0;
                byte_done_q <= 1'b0;
                case (cmd_byte_d)
                  CMD_READ: state_q <= ST_ADDR;
                  CMD_JEDEC: begin
                    state_q     <= ST_ID;
                    shift_out_q <= id_byte(JEDEC_ID, 2'd0);
                    id_idx_q    <= 2'd1;
                  end
                  CMD_RDSR: begin
                    state_q     <= ST_STAT;
                    shift_out_q <= STATUS;
                  end
                  default: state_q <= ST_IGNORE;
                endcase
              end
            end
          end

          ST_ADDR: begin
            if (sck_rise) begin
              shift_in_q <= {shift_in_q[SHIFT_W-2:0], mosi_s};
              bit_cnt_q  <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'(ADDR_BITS_ON_WIRE - 1)) begin
                mem_addr_q <= addr_d;
                mem_rd_q   <= 1'b1;
                state_q    <= ST_FETCH;
              end
            end
          end

          ST_FETCH: begin
            if (rd_pend_q) begin
              shift_out_q <= mem_rdata;
              mem_addr_q  <= mem_addr_q + ADDR_ONE;
              mem_rd_q    <= 1'b1;
              state_q     <= ST_DATA;
            end
          end

          ST_DATA, ST_ID, ST_STAT: begin
            if (state_q == ST_DATA && rd_pend_q) begin
              pref_q       <= mem_rdata;
              pref_valid_q <= 1'b1;
            end
            if (sck_fall) begin
              miso_q      <= out_byte_d[7];
              shift_out_q <= {out_byte_d[6:0], 1'b0};
              out_cnt_q   <= out_cnt_q + 3'd1;
              byte_done_q <= (out_cnt_q == 3'd7);
              if (byte_done_q) begin
                if (state_q == ST_DATA) begin
                  pref_valid_q <= 1'b0;
                  mem_addr_q   <= mem_addr_q + ADDR_ONE;
                  mem_rd_q     <= 1'b1;
                end
                if (state_q == ST_ID && id_idx_q != 2'd3) begin
                  id_idx_q <= id_idx_q + 2'd1;
                end
              end
            end
          end

          ST_IGNORE: miso_q <= 1'b0;

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso = miso_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: an SPI initiator model, a byte-array
// memory filled with i^8'hA5, and queues of expected MISO bytes and memory read addresses.
module tb_spi_flash_responder;

  localparam int ADDR_BITS = 12;
  localparam int HALF      = 4;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 spi_clk;
  logic                 spi_cs_n;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 mem_rd;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_rdata;
  logic                 busy;
  logic [7:0]           last_cmd;

  logic [7:0]           mem [0:(1<<ADDR_BITS)-1];
  logic [7:0]           exp_bytes[$];
  logic [ADDR_BITS-1:0] exp_addrs[$];
  logic [ADDR_BITS-1:0] exp_a;
  int                   checks = 0;
  int                   fails  = 0;
  int                   rd_count = 0;

  spi_flash_responder #(
    .ADDR_BITS (ADDR_BITS),
    .JEDEC_ID  (24'hEF4017),
    .STATUS    (8'h00)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .last_cmd  (last_cmd)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 8'(i) ^ 8'hA5;
    mem_rdata = 8'h00;
  end

  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Every read strobe is matched against the next expected address.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && mem_rd === 1'b1) begin
      rd_count++;
      checks++;
      if (exp_addrs.size() == 0) begin
        fails++;
        $display("[TB] FAIL mem_rd_addr: got unexpected read of %03h, expected no read", mem_addr);
      end else begin
        exp_a = exp_addrs.pop_front();
        if (mem_addr !== exp_a) begin
          fails++;
          $display("[TB] FAIL mem_rd_addr: got %03h, expected %03h", mem_addr, exp_a);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_clk  = 1'b0;
    spi_mosi = b;
    repeat (HALF) @(negedge clock);
    m = spi_miso;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic cs_begin();
    @(negedge clock);
    spi_clk  = 1'b0;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic cs_end();
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clock);
    spi_clk = 1'b0;
    repeat (2 * HALF) @(negedge clock);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic m;
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i], m);
  endtask

  task automatic read_bytes(input string name, input int n);
    logic       m;
    logic [7:0] got, e;
    for (int k = 0; k < n; k++) begin
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        spi_bit(1'b0, m);
        got[i] = m;
      end
      checks++;
      if (exp_bytes.size() == 0) begin
        fails++;
        $display("[TB] FAIL %s byte %0d: got %02h, expected nothing queued", name, k, got);
      end else begin
        e = exp_bytes.pop_front();
        if (got !== e) begin
          fails++;
          $display("[TB] FAIL %s byte %0d: got %02h, expected %02h", name, k, got, e);
        end
      end
    end
  endtask

  task automatic push_reads(input logic [ADDR_BITS-1:0] start, input int n);
    for (int k = 0; k < n; k++) exp_addrs.push_back(start + ADDR_BITS'(k));
  endtask

  task automatic do_xfer(input string name, input logic [7:0] cmd, input logic has_addr,
                         input logic [23:0] addr, input int nbytes);
    cs_begin();
    send_bits({24'h0, cmd}, 8);
    if (has_addr) send_bits({8'h0, addr}, 24);
    read_bytes(name, nbytes);
    cs_end();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (spi_miso !== 1'b0) begin fails++; $display("[TB] FAIL reset_miso: got %b, expected 0", spi_miso); end
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_rd: got %b, expected 0", mem_rd); end
    checks++; if (mem_addr !== 12'h000) begin fails++; $display("[TB] FAIL reset_mem_addr: got %03h, expected 000", mem_addr); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (last_cmd !== 8'h00) begin fails++; $display("[TB] FAIL reset_last_cmd: got %02h, expected 00", last_cmd); end
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_read_basic();
    rd_count = 0;
    exp_bytes.push_back(8'hB5); exp_bytes.push_back(8'hB4);
    exp_bytes.push_back(8'hB7); exp_bytes.push_back(8'hB6);
    push_reads(12'h010, 5);
    do_xfer("read_basic", 8'h03, 1'b1, 24'h000010, 4);
    checks++; if (rd_count !== 5) begin fails++; $display("[TB] FAIL read_basic_rd_count: got %0d, expected 5", rd_count); end
    checks++; if (last_cmd !== 8'h03) begin fails++; $display("[TB] FAIL read_basic_last_cmd: got %02h, expected 03", last_cmd); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL read_basic_busy_after: got %b, expected 0", busy); end
  endtask

  task automatic test_read_wrap();
    rd_count = 0;
    exp_bytes.push_back(8'h5B); exp_bytes.push_back(8'h5A); exp_bytes.push_back(8'hA5);
    push_reads(12'hFFE, 4);
    do_xfer("read_wrap", 8'h03, 1'b1, 24'h000FFE, 3);
    exp_bytes.push_back(8'h5B); exp_bytes.push_back(8'h5A); exp_bytes.push_back(8'hA5);
    push_reads(12'hFFE, 4);
    do_xfer("read_wrap_upper", 8'h03, 1'b1, 24'hAB0FFE, 3);
    checks++; if (rd_count !== 8) begin fails++; $display("[TB] FAIL read_wrap_rd_count: got %0d, expected 8", rd_count); end
  endtask

  task automatic test_id_status();
    rd_count = 0;
    exp_bytes.push_back(8'hEF); exp_bytes.push_back(8'h40);
    exp_bytes.push_back(8'h17); exp_bytes.push_back(8'h00);
    do_xfer("jedec", 8'h9F, 1'b0, 24'h0, 4);
    checks++; if (last_cmd !== 8'h9F) begin fails++; $display("[TB] FAIL jedec_last_cmd: got %02h, expected 9F", last_cmd); end
    for (int k = 0; k < 3; k++) exp_bytes.push_back(8'h00);
    do_xfer("rdsr", 8'h05, 1'b0, 24'h0, 3);
    checks++; if (last_cmd !== 8'h05) begin fails++; $display("[TB] FAIL rdsr_last_cmd: got %02h, expected 05", last_cmd); end
    checks++; if (rd_count !== 0) begin fails++; $display("[TB] FAIL id_status_rd_count: got %0d, expected 0", rd_count); end
  endtask

  task automatic test_abort();
    cs_begin();
    send_bits(32'h03, 8);
    send_bits(32'h2AB, 10);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
    checks++; if (spi_miso !== 1'b0) begin fails++; $display("[TB] FAIL abort_miso: got %b, expected 0", spi_miso); end
    spi_clk = 1'b0;
    repeat (2 * HALF) @(negedge clock);
    exp_bytes.push_back(8'hA5);
    push_reads(12'h000, 2);
    do_xfer("abort_then_read", 8'h03, 1'b1, 24'h000000, 1);
  endtask

  task automatic test_ignore();
    rd_count = 0;
    cs_begin();
    send_bits(32'h0B, 8);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL ignore_busy: got %b, expected 1", busy); end
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
    read_bytes("ignore", 2);
    cs_end();
    checks++; if (last_cmd !== 8'h0B) begin fails++; $display("[TB] FAIL ignore_last_cmd: got %02h, expected 0B", last_cmd); end
    checks++; if (rd_count !== 0) begin fails++; $display("[TB] FAIL ignore_rd_count: got %0d, expected 0", rd_count); end
  endtask

  task automatic test_reset_mid_data();
    push_reads(12'h100, 2);
    cs_begin();
    send_bits(32'h03, 8);
    send_bits(32'h000100, 24);
    send_bits(32'h0, 3);
    checks++; if (spi_miso !== 1'b1) begin fails++; $display("[TB] FAIL mid_data_miso: got %b, expected 1", spi_miso); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (spi_miso !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_miso: got %b, expected 0", spi_miso); end
    checks++; if (mem_rd !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_mem_rd: got %b, expected 0", mem_rd); end
    checks++; if (mem_addr !== 12'h000) begin fails++; $display("[TB] FAIL async_reset_mem_addr: got %03h, expected 000", mem_addr); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_busy: got %b, expected 0", busy); end
    checks++; if (last_cmd !== 8'h00) begin fails++; $display("[TB] FAIL async_reset_last_cmd: got %02h, expected 00", last_cmd); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    send_bits(32'h9F, 8);
    exp_bytes.push_back(8'h00);
    read_bytes("post_reset_locked", 1);
    checks++; if (last_cmd !== 8'h00) begin fails++; $display("[TB] FAIL post_reset_last_cmd: got %02h, expected 00", last_cmd); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_busy: got %b, expected 0", busy); end
    cs_end();
    exp_bytes.push_back(8'hA4);
    push_reads(12'h001, 2);
    do_xfer("read_after_reset", 8'h03, 1'b1, 24'h000001, 1);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_wrap();
    test_id_status();
    test_abort();
    test_ignore();
    test_reset_mid_data();
    repeat (4) @(negedge clock);
    checks++;
    if (exp_addrs.size() != 0) begin
      fails++;
      $display("[TB] FAIL missing_reads: got %0d reads outstanding, expected 0", exp_addrs.size());
    end
    checks++;
    if (exp_bytes.size() != 0) begin
      fails++;
      $display("[TB] FAIL leftover_bytes: got %0d bytes unconsumed, expected 0", exp_bytes.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
